// File: rtl/rx_pkg.sv
// Shared encodings and default parameter values for the receive sync path.
package rx_pkg;

   typedef enum logic [1:0] {
      ST_LOS  = 2'd0,
      ST_ACQ  = 2'd1,
      ST_SYNC = 2'd2,
      ST_SLIP = 2'd3
   } sync_state_e;

   localparam logic [7:0] K28_5 = 8'hBC;

   localparam int DEF_COMMA_CNT    = 3;
   localparam int DEF_SLIP_TIMEOUT = 20;
   localparam int DEF_SLIP_WAIT    = 4;
   localparam int DEF_ERR_LIMIT    = 4;
   localparam int DEF_GOOD_RUN     = 4;
   localparam int DEF_ERRCNT_W     = 16;

endpackage

// File: rtl/rx_err_monitor.sv
// Purpose: bad-symbol credit / good-run bookkeeping while in sync, plus saturating error count.
// Latency: loss_of_sync is same-cycle from the offending symbol; err_cnt updates one cycle later.
// Backpressure: none; sym_valid qualifies every symbol and nothing is ever stalled.
module rx_err_monitor #(
   parameter int ERR_LIMIT = 4,
   parameter int GOOD_RUN  = 4,
   parameter int ERRCNT_W  = 16
)(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                sym_valid,
   input  logic                code_err,
   input  logic                disp_err,
   input  logic                err_clr,
   input  logic                in_sync,
   output logic                loss_of_sync,
   output logic [ERRCNT_W-1:0] err_cnt
);

   logic       bad;
   logic       good;
   logic [3:0] credit;
   logic [3:0] run;

   assign bad  = sym_valid & (code_err | disp_err);
   assign good = sym_valid & ~bad;

   // Combinational so the FSM can leave SYNC on the very symbol that exhausts the credit.
   assign loss_of_sync = in_sync & bad & (credit == 4'(ERR_LIMIT - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         credit <= '0;
         run    <= '0;
      end else if (!in_sync || loss_of_sync) begin
         credit <= '0;
         run    <= '0;
      end else if (bad) begin
         credit <= credit + 4'd1;
         run    <= '0;
      end else if (good) begin
         if (run == 4'(GOOD_RUN - 1)) begin
            run <= '0;
            if (credit != 4'd0) credit <= credit - 4'd1;
         end else begin
            run <= run + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         err_cnt <= '0;
      else if (err_clr)
         err_cnt <= '0;
      else if (bad && (err_cnt != '1))
         err_cnt <= err_cnt + 1'b1;
   end

endmodule

// File: rtl/rx_sync_ctrl.sv
// Purpose: word alignment via bitslip requests and link sync tracking on decoded 8b/10b symbols.
// Latency: all outputs registered, one cycle after the symbol that causes a change.
// Backpressure: none; sym_valid=0 cycles freeze symbol counters, SLIP wait counts raw cycles.
module rx_sync_ctrl
   import rx_pkg::*;
#(
   parameter int COMMA_CNT    = DEF_COMMA_CNT,
   parameter int SLIP_TIMEOUT = DEF_SLIP_TIMEOUT,
   parameter int SLIP_WAIT    = DEF_SLIP_WAIT,
   parameter int ERR_LIMIT    = DEF_ERR_LIMIT,
   parameter int GOOD_RUN     = DEF_GOOD_RUN,
   parameter int ERRCNT_W     = DEF_ERRCNT_W
)(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                sym_valid,
   input  logic [7:0]          pdata,
   input  logic                kout,
   input  logic                code_err,
   input  logic                disp_err,
   input  logic                err_clr,
   output logic                bitslip,
   output logic                link_up,
   output logic [1:0]          sync_state,
   output logic [ERRCNT_W-1:0] err_cnt
);

   sync_state_e state_q, state_d;
   logic [7:0]  tmo_q, tmo_d;
   logic [3:0]  comma_q, comma_d;
   logic [3:0]  slip_q, slip_d;
   logic [3:0]  comma_inc;
   logic        comma;
   logic        bad;
   logic        loss_of_sync;

   assign comma     = sym_valid & kout & (pdata == K28_5) & ~code_err;
   assign bad       = sym_valid & (code_err | disp_err);
   assign comma_inc = comma_q + 4'd1;

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      comma_d = comma_q;
      slip_d  = slip_q;
      case (state_q)
         ST_LOS: begin
            if (comma) begin
               state_d = ST_ACQ;
               comma_d = 4'd1;
               tmo_d   = '0;
            end else if (sym_valid) begin
               if (tmo_q == 8'(SLIP_TIMEOUT - 1)) begin
                  state_d = ST_SLIP;
                  tmo_d   = '0;
                  slip_d  = '0;
               end else begin
                  tmo_d = tmo_q + 8'd1;
               end
            end
         end
         ST_ACQ: begin
            // A bad symbol wins even if it also looks like a comma (disparity error on K28.5).
            if (bad) begin
               state_d = ST_LOS;
               comma_d = '0;
            end else if (comma) begin
               if (comma_inc >= 4'(COMMA_CNT)) begin
                  state_d = ST_SYNC;
                  comma_d = '0;
               end else begin
                  comma_d = comma_inc;
               end
            end
         end
         ST_SYNC: begin
            if (loss_of_sync) begin
               state_d = ST_LOS;
               tmo_d   = '0;
               comma_d = '0;
            end
         end
         ST_SLIP: begin
            if (slip_q == 4'(SLIP_WAIT - 1)) begin
               state_d = ST_LOS;
               slip_d  = '0;
            end else begin
               slip_d = slip_q + 4'd1;
            end
         end
         default: state_d = ST_LOS;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_LOS;
         tmo_q   <= '0;
         comma_q <= '0;
         slip_q  <= '0;
         bitslip <= 1'b0;
         link_up <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         comma_q <= comma_d;
         slip_q  <= slip_d;
         bitslip <= (state_d == ST_SLIP) && (state_q != ST_SLIP);
         link_up <= (state_d == ST_SYNC);
      end
   end

   assign sync_state = state_q;

   rx_err_monitor #(
      .ERR_LIMIT (ERR_LIMIT),
      .GOOD_RUN  (GOOD_RUN),
      .ERRCNT_W  (ERRCNT_W)
   ) u_err_monitor (
      .clk          (clk),
      .reset_n      (reset_n),
      .sym_valid    (sym_valid),
      .code_err     (code_err),
      .disp_err     (disp_err),
      .err_clr      (err_clr),
      .in_sync      (state_q == ST_SYNC),
      .loss_of_sync (loss_of_sync),
      .err_cnt      (err_cnt)
   );

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Directed bench for rx_sync_ctrl with a per-symbol expectation queue.
module tb_rx_sync_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       sym_valid = 1'b0;
   logic [7:0] pdata = 8'h00;
   logic       kout = 1'b0;
   logic       code_err = 1'b0;
   logic       disp_err = 1'b0;
   logic       err_clr = 1'b0;
   logic       bitslip;
   logic       link_up;
   logic [1:0] sync_state;
   logic [3:0] err_cnt;

   always #5 clk = ~clk;

   rx_sync_ctrl #(.ERRCNT_W(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .sym_valid  (sym_valid),
      .pdata      (pdata),
      .kout       (kout),
      .code_err   (code_err),
      .disp_err   (disp_err),
      .err_clr    (err_clr),
      .bitslip    (bitslip),
      .link_up    (link_up),
      .sync_state (sync_state),
      .err_cnt    (err_cnt)
   );

   typedef struct packed {
      logic [1:0] st;
      logic       lk;
      logic       bs;
      logic [3:0] ec;
   } exp_t;

   exp_t       sb[$];
   int         tests = 0;
   int         fails = 0;
   logic [3:0] exp_err = 4'd0;
   string      cur_tag = "none";

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      assert (act === exp) else begin
         fails++;
         $error("FAIL %s/%s: observed %0h expected %0h", cur_tag, name, act, exp);
      end
   endtask

   // Drive one symbol cycle; expected outputs after the edge are queued, then popped and compared.
   task automatic sym(input logic v, input logic k, input logic [7:0] d, input logic ce,
                      input logic de, input logic clr, input logic [1:0] est,
                      input logic elk, input logic ebs);
      exp_t e;
      sym_valid = v; kout = k; pdata = d; code_err = ce; disp_err = de; err_clr = clr;
      if (clr) exp_err = 4'd0;
      else if (v && (ce || de) && exp_err != 4'hF) exp_err = exp_err + 4'd1;
      e = '{st: est, lk: elk, bs: ebs, ec: exp_err};
      sb.push_back(e);
      @(posedge clk); #1;
      sym_valid = 1'b0; kout = 1'b0; pdata = 8'h00; code_err = 1'b0; disp_err = 1'b0; err_clr = 1'b0;
      e = sb.pop_front();
      check("sync_state", 16'(sync_state), 16'(e.st));
      check("link_up",    16'(link_up),    16'(e.lk));
      check("bitslip",    16'(bitslip),    16'(e.bs));
      check("err_cnt",    16'(err_cnt),    16'(e.ec));
   endtask

   task automatic kc(input logic [1:0] est, input logic elk);
      sym(1'b1, 1'b1, 8'hBC, 1'b0, 1'b0, 1'b0, est, elk, 1'b0);
   endtask
   task automatic dsym(input logic [1:0] est, input logic elk, input logic ebs);
      sym(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, est, elk, ebs);
   endtask
   task automatic cerr(input logic [1:0] est, input logic elk);
      sym(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, est, elk, 1'b0);
   endtask
   task automatic idle(input logic [1:0] est, input logic elk);
      sym(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, est, elk, 1'b0);
   endtask
   task automatic clear_err();
      sym(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
   endtask

   initial begin
      cur_tag = "reset";
      repeat (2) @(posedge clk);
      #1;
      check("sync_state", 16'(sync_state), 16'd0);
      check("link_up",    16'(link_up),    16'd0);
      check("bitslip",    16'(bitslip),    16'd0);
      check("err_cnt",    16'(err_cnt),    16'd0);
      reset_n = 1'b1;

      cur_tag = "acq3";
      kc(2'd1, 1'b0);
      kc(2'd1, 1'b0);
      kc(2'd2, 1'b1);

      cur_tag = "sync_loss";
      cerr(2'd2, 1'b1); dsym(2'd2, 1'b1, 1'b0);
      cerr(2'd2, 1'b1); dsym(2'd2, 1'b1, 1'b0);
      cerr(2'd2, 1'b1); dsym(2'd2, 1'b1, 1'b0);
      cerr(2'd0, 1'b0);
      check("err_is_4", 16'(err_cnt), 16'd4);
      clear_err();

      cur_tag = "retire";
      kc(2'd1, 1'b0); kc(2'd1, 1'b0); kc(2'd2, 1'b1);
      for (int i = 0; i < 10; i++) begin
         cerr(2'd2, 1'b1);
         idle(2'd2, 1'b1);
         repeat (4) dsym(2'd2, 1'b1, 1'b0);
      end
      check("err_is_10", 16'(err_cnt), 16'd10);
      repeat (3) cerr(2'd2, 1'b1);
      cerr(2'd0, 1'b0);
      clear_err();

      cur_tag = "acq_err";
      kc(2'd1, 1'b0); kc(2'd1, 1'b0);
      sym(1'b1, 1'b1, 8'hBC, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      kc(2'd1, 1'b0); kc(2'd1, 1'b0); kc(2'd2, 1'b1);
      repeat (3) cerr(2'd2, 1'b1);
      cerr(2'd0, 1'b0);
      clear_err();

      cur_tag = "slip1";
      for (int i = 0; i < 19; i++) dsym(2'd0, 1'b0, 1'b0);
      dsym(2'd3, 1'b0, 1'b1);
      cerr(2'd3, 1'b0);
      dsym(2'd3, 1'b0, 1'b0);
      dsym(2'd3, 1'b0, 1'b0);
      dsym(2'd0, 1'b0, 1'b0);
      cur_tag = "slip2";
      for (int i = 0; i < 19; i++) dsym(2'd0, 1'b0, 1'b0);
      dsym(2'd3, 1'b0, 1'b1);

      cur_tag = "reset_in_slip";
      reset_n = 1'b0;
      #1;
      exp_err = 4'd0;
      check("bitslip",    16'(bitslip),    16'd0);
      check("sync_state", 16'(sync_state), 16'd0);
      check("link_up",    16'(link_up),    16'd0);
      check("err_cnt",    16'(err_cnt),    16'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      cur_tag = "saturate";
      for (int i = 0; i < 17; i++) cerr(2'd0, 1'b0);
      check("err_sat", 16'(err_cnt), 16'd15);
      cur_tag = "clr_vs_bad";
      sym(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
      cerr(2'd0, 1'b0);
      idle(2'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
